modport_alu: RTL and testbench
==============================

MODPORT_ALU -- requirements
Module: modport_alu

Interface
REQ-001 Parameter DIN_W, default 16, width of data_i and of each register.
REQ-002 Parameter DOUT_W, default 32, width of data_o; SHALL equal 2*DIN_W.
REQ-003 Parameter NREG, default 4, register count; reg_sel width = log2(NREG).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 data_i  input  16  operand / write data.
REQ-007 reg_sel  input  2  register index 0..3.
REQ-008 instru  input  2  opcode: 00 WRITE, 01 ADD, 10 SUB, 11 MUL.
REQ-009 valid_i  input  1  request strobe; one request per cycle while high, no backpressure.
REQ-010 data_o  output  32  result.
REQ-011 valid_o  output  1  result-valid strobe, one cycle per accepted request.

Function
REQ-012 Internal state SHALL be 4 registers R[0..3], 16 bits each.
REQ-013 A request SHALL be accepted on every rising clk edge where valid_i=1; when valid_i=0, no state changes except valid_o deasserting.
REQ-014 WRITE (00): R[reg_sel] <= data_i; data_o <= {16'h0, data_i}.
REQ-015 ADD (01): data_o <= zero-extended R[reg_sel] + data_i, 17-bit carry preserved in bit 16, bits 31:17 = 0.
REQ-016 SUB (10): data_o <= ({16'h0,R[reg_sel]} - {16'h0,data_i}) modulo 2^32, so a negative result appears as 32-bit two's complement.
REQ-017 MUL (11): data_o <= unsigned R[reg_sel] * data_i, full 32-bit product.
REQ-018 Only WRITE SHALL modify registers; ADD/SUB/MUL leave R unchanged.
REQ-019 Latency SHALL be exactly 1 cycle: valid_o=1 in the cycle after the accepting edge, data_o valid in that same cycle.
REQ-020 Back-to-back requests SHALL produce back-to-back valid_o pulses; an operation on a register written in the previous cycle SHALL use the new value.
REQ-021 data_o SHALL hold its last value while valid_o=0.
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-023 While rst=0: R[0..3]=0, data_o=0, valid_o=0, asynchronously, independent of clk.
REQ-024 Reset asserted with a request in flight SHALL drop that result; no valid_o pulse follows.
REQ-025 Requests SHALL be accepted from the first rising edge after rst deasserts.

Structure
REQ-026 Package modport_alu_pkg SHALL hold the opcode enum (OP_WRITE, OP_ADD, OP_SUB, OP_MUL) and the DIN_W/DOUT_W/NREG defaults.
REQ-027 Sub-module modport_alu_regfile SHALL implement the 4x16 register file: one write port, one async read port, async active-low reset.
REQ-028 Top module SHALL contain the opcode decode, the arithmetic, and the output registers.

Verification
REQ-029 Reset then ADD reg 2 with data_i=5 -> next cycle valid_o=1, data_o=32'h0000_0005 (register is 0).
REQ-030 WRITE R1=16'hFFFF, then ADD R1 with 16'h0001 -> data_o=32'h0001_0000.
REQ-031 WRITE R0=3, then SUB R0 with 5 -> data_o=32'hFFFF_FFFE.
REQ-032 WRITE R3=16'hFFFF, then MUL R3 with 16'hFFFF -> data_o=32'hFFFE_0001.
REQ-033 Four consecutive WRITEs (R0..R3 = 1,2,3,4), then four ADDs with 10 -> four consecutive valid_o pulses, data_o 11,12,13,14.
REQ-034 Issue MUL, then assert rst before the next edge -> valid_o stays 0, data_o=0, all registers read back 0.

Source files
------------

// File: rtl/modport_alu_pkg.sv
// Shared opcode encoding and default geometry for the modport_alu slice.
package modport_alu_pkg;

  localparam int unsigned DEF_DIN_W  = 16;
  localparam int unsigned DEF_DOUT_W = 32;
  localparam int unsigned DEF_NREG   = 4;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_MUL   = 2'b11
  } op_e;

endpackage

// File: rtl/modport_alu_regfile.sv
// NREG x DIN_W register file: one synchronous write port, one asynchronous read port.
module modport_alu_regfile
  import modport_alu_pkg::*;
#(
  parameter int unsigned DIN_W = DEF_DIN_W,
  parameter int unsigned NREG  = DEF_NREG
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_wsel,
  input  logic [DIN_W-1:0]        i_wdata,
  input  logic [$clog2(NREG)-1:0] i_rsel,
  output logic [DIN_W-1:0]        o_rdata
);

  logic [DIN_W-1:0] r_regs [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wsel] <= i_wdata;
    end
  end

  assign o_rdata = r_regs[i_rsel];

endmodule

// File: rtl/modport_alu.sv
// Register-file ALU: WRITE/ADD/SUB/MUL on R[reg_sel] with data_i, one-cycle registered result.
module modport_alu
  import modport_alu_pkg::*;
#(
  parameter int unsigned DIN_W  = DEF_DIN_W,
  parameter int unsigned DOUT_W = DEF_DOUT_W,
  parameter int unsigned NREG   = DEF_NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_W-1:0]        data_i,
  input  logic [$clog2(NREG)-1:0] reg_sel,
  input  logic [1:0]              instru,
  input  logic                    valid_i,
  output logic [DOUT_W-1:0]       data_o,
  output logic                    valid_o
);

  op_e               w_op;
  logic              w_we;
  logic [DIN_W-1:0]  w_rdata;
  logic [DOUT_W-1:0] w_a;
  logic [DOUT_W-1:0] w_b;
  logic [DOUT_W-1:0] w_result;
  logic [DOUT_W-1:0] r_data_o;
  logic              r_valid_o;

  assign w_op = op_e'(instru);
  assign w_we = valid_i && (w_op == OP_WRITE);

  modport_alu_regfile #(
    .DIN_W (DIN_W),
    .NREG  (NREG)
  ) u_regfile (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_we),
    .i_wsel  (reg_sel),
    .i_wdata (data_i),
    .i_rsel  (reg_sel),
    .o_rdata (w_rdata)
  );

  // Zero-extend both operands so ADD keeps its carry and SUB wraps modulo 2^DOUT_W.
  assign w_a = {{(DOUT_W-DIN_W){1'b0}}, w_rdata};
  assign w_b = {{(DOUT_W-DIN_W){1'b0}}, data_i};

  always_comb begin
    w_result = w_b;
    case (w_op)
      OP_WRITE: w_result = w_b;
      OP_ADD:   w_result = w_a + w_b;
      OP_SUB:   w_result = w_a - w_b;
      OP_MUL:   w_result = w_a * w_b;
      default:  w_result = w_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
    end else begin
      r_valid_o <= valid_i;
      if (valid_i) begin
        r_data_o <= w_result;
      end
    end
  end

  assign data_o  = r_data_o;
  assign valid_o = r_valid_o;

endmodule

// File: tb/tb_modport_alu.sv
// Directed self-checking bench for modport_alu with hand-computed expected results.
module tb_modport_alu;

  logic        clk;
  logic        rst;
  logic [15:0] data_i;
  logic [1:0]  reg_sel;
  logic [1:0]  instru;
  logic        valid_i;
  logic [31:0] data_o;
  logic        valid_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [1:0] WR  = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;
  localparam logic [1:0] MUL = 2'b11;

  modport_alu #(
    .DIN_W  (16),
    .DOUT_W (32),
    .NREG   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .reg_sel (reg_sel),
    .instru  (instru),
    .valid_i (valid_i),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request at the falling edge; return just after the accepting edge.
  task automatic req(input logic [1:0] op, input logic [1:0] sel, input logic [15:0] d);
    @(negedge clk);
    instru  = op;
    reg_sel = sel;
    data_i  = d;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 16'h1234;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    reg_sel = '0;
    instru  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    req(ADD, 2'd2, 16'd5);
    check("add_r2_zero_valid", {31'b0, valid_o}, 32'd1);
    check("add_r2_zero_data", data_o, 32'h0000_0005);

    idle();
    check("idle_valid", {31'b0, valid_o}, 32'd0);
    check("idle_hold", data_o, 32'h0000_0005);

    req(WR, 2'd1, 16'hFFFF);
    check("write_r1_data", data_o, 32'h0000_FFFF);
    req(ADD, 2'd1, 16'h0001);
    check("add_carry", data_o, 32'h0001_0000);

    req(WR, 2'd0, 16'd3);
    check("write_r0_data", data_o, 32'h0000_0003);
    req(SUB, 2'd0, 16'd5);
    check("sub_negative", data_o, 32'hFFFF_FFFE);

    req(WR, 2'd3, 16'hFFFF);
    req(MUL, 2'd3, 16'hFFFF);
    check("mul_max", data_o, 32'hFFFE_0001);

    req(ADD, 2'd1, 16'h0000);
    check("r1_unchanged", data_o, 32'h0000_FFFF);
    req(SUB, 2'd3, 16'hFFFF);
    check("sub_equal", data_o, 32'h0000_0000);

    for (int i = 0; i < 4; i++) begin
      req(WR, 2'(i), 16'(i + 1));
      check("b2b_write_valid", {31'b0, valid_o}, 32'd1);
      check("b2b_write_data", data_o, 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      req(ADD, 2'(i), 16'd10);
      check("b2b_add_valid", {31'b0, valid_o}, 32'd1);
      check("b2b_add_data", data_o, 32'(i + 11));
    end
    idle();
    check("b2b_end_valid", {31'b0, valid_o}, 32'd0);

    req(MUL, 2'd3, 16'd7);
    check("mul_before_reset", data_o, 32'd28);
    rst = 1'b0;
    #1;
    check("async_reset_valid", {31'b0, valid_o}, 32'd0);
    check("async_reset_data", data_o, 32'd0);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("reset_hold_valid", {31'b0, valid_o}, 32'd0);
    check("reset_hold_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      req(ADD, 2'(i), 16'd0);
      check("post_reset_valid", {31'b0, valid_o}, 32'd1);
      check("post_reset_reg", data_o, 32'd0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
